// File: rtl/se_channel_scale_pkg.sv
// rtl/se_channel_scale_pkg.sv - shared types and fixed-point constants for the SE channel scale stage
// Purpose: FSM state type, Q-format 1.0 constant and signed saturation limits.
// Ports: none (package).
package se_scale_pkg;

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        SCALE = 2'd1,
        DRAIN = 2'd2
    } state_e;

    // Q-format 1.0 for a given number of fractional bits.
    function automatic logic [63:0] q_one(input int frac);
        return 64'd1 << frac;
    endfunction

    // Largest positive value of a signed word of the given width.
    function automatic logic signed [63:0] sat_hi(input int width);
        return (64'sd1 <<< (width - 1)) - 64'sd1;
    endfunction

    // Most negative value of a signed word of the given width.
    function automatic logic signed [63:0] sat_lo(input int width);
        return -(64'sd1 <<< (width - 1));
    endfunction

endpackage

// File: rtl/se_channel_scale_if.sv
// rtl/se_channel_scale_if.sv - gate/feature/output handshake bundle of the SE channel scale stage
// Purpose: groups the gate, feature and output streams plus status flags.
// Ports: master = producer/consumer side (testbench, neighbours), slave = scale block.
interface se_channel_scale_if #(
    parameter int pDATA_WIDTH = 32
);
    logic                   gate_valid;
    logic [pDATA_WIDTH-1:0] gate_in;
    logic                   gate_ready;
    logic                   feat_valid;
    logic [pDATA_WIDTH-1:0] feat_in;
    logic                   feat_ready;
    logic                   out_valid;
    logic [pDATA_WIDTH-1:0] out_data;
    logic                   out_ready;
    logic                   busy;
    logic                   done;

    modport master (
        output gate_valid, gate_in, feat_valid, feat_in, out_ready,
        input  gate_ready, feat_ready, out_valid, out_data, busy, done
    );

    modport slave (
        input  gate_valid, gate_in, feat_valid, feat_in, out_ready,
        output gate_ready, feat_ready, out_valid, out_data, busy, done
    );
endinterface

// File: rtl/se_channel_scale_mul.sv
// rtl/se_channel_scale_mul.sv - two-stage signed fixed-point multiply with round half-up and saturation
// Purpose: stage 1 registers the full product, stage 2 rounds, shifts and saturates.
// Ports: clk, rst_n (async active-low); in_valid_i/a_i/b_i operands; out_ready_i downstream ready;
//        adv_o pipeline advance enable; s1_valid_o stage-1 occupancy; out_valid_o/out_data_o result.
module fxp_mul_round_sat
    import se_scale_pkg::*;
#(
    parameter int pDATA_WIDTH = 32,
    parameter int pFRAC_NUM   = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          in_valid_i,
    input  logic signed [pDATA_WIDTH-1:0] a_i,
    input  logic signed [pDATA_WIDTH-1:0] b_i,
    input  logic                          out_ready_i,
    output logic                          adv_o,
    output logic                          s1_valid_o,
    output logic                          out_valid_o,
    output logic        [pDATA_WIDTH-1:0] out_data_o
);
    localparam int W  = pDATA_WIDTH;
    localparam int F  = pFRAC_NUM;
    // One guard bit so adding the rounding constant can never wrap.
    localparam int SW = 2 * W + 1;

    localparam logic signed [SW-1:0] RND    = SW'(1) << (F - 1);
    localparam logic signed [SW-1:0] HI_EXT = SW'(sat_hi(W));
    localparam logic signed [SW-1:0] LO_EXT = SW'(sat_lo(W));

    logic                    s1_valid_q;
    logic signed [2*W-1:0]   s1_prod_q;
    logic                    s2_valid_q;
    logic        [W-1:0]     s2_data_q;

    logic signed [2*W-1:0]   prod_d;
    logic signed [SW-1:0]    sum_d;
    logic signed [SW-1:0]    shifted_d;
    logic        [W-1:0]     sat_d;

    // The whole pipe moves together; a stalled output freezes both stages.
    assign adv_o = ~s2_valid_q | out_ready_i;

    assign prod_d    = a_i * b_i;
    assign sum_d     = $signed({s1_prod_q[2*W-1], s1_prod_q}) + RND;
    assign shifted_d = sum_d >>> F;

    always_comb begin
        sat_d = shifted_d[W-1:0];
        if (shifted_d > HI_EXT) begin
            sat_d = HI_EXT[W-1:0];
        end else if (shifted_d < LO_EXT) begin
            sat_d = LO_EXT[W-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_prod_q  <= '0;
            s2_valid_q <= 1'b0;
            s2_data_q  <= '0;
        end else if (adv_o) begin
            s1_valid_q <= in_valid_i;
            if (in_valid_i) begin
                s1_prod_q <= prod_d;
            end
            s2_valid_q <= s1_valid_q;
            // Data only moves with a valid beat so out_data holds while idle.
            if (s1_valid_q) begin
                s2_data_q <= sat_d;
            end
        end
    end

    assign s1_valid_o  = s1_valid_q;
    assign out_valid_o = s2_valid_q;
    assign out_data_o  = s2_data_q;

endmodule

// File: rtl/se_channel_scale.sv
// rtl/se_channel_scale.sv - per-channel gate capture and feature-map scaling (squeeze-excitation)
// Purpose: loads one clamped gate per channel, then scales each feature word by its channel gate.
// Ports: clk, rst (async active-low); bus (slave) carrying gate, feature and output streams,
//        busy and done status.
module se_channel_scale
    import se_scale_pkg::*;
#(
    parameter int pDATA_WIDTH = 32,
    parameter int pFRAC_NUM   = 16,
    parameter int pCHANNELS   = 16,
    parameter int pPIXELS     = 49
) (
    input  logic          clk,
    input  logic          rst,
    se_channel_scale_if.slave bus
);
    localparam int W  = pDATA_WIDTH;
    localparam int CW = $clog2(pCHANNELS);
    localparam int PW = (pPIXELS > 1) ? $clog2(pPIXELS) : 1;

    localparam logic signed [W-1:0]  Q_ONE     = W'(q_one(pFRAC_NUM));
    localparam logic        [CW-1:0] CHAN_LAST = CW'(pCHANNELS - 1);
    localparam logic        [PW-1:0] PIX_LAST  = PW'(pPIXELS - 1);

    state_e          state_q, state_d;
    logic [CW-1:0]   chan_cnt_q, chan_cnt_d;
    logic [PW-1:0]   pix_cnt_q, pix_cnt_d;
    logic [W-1:0]    gate_q [pCHANNELS];

    logic            gate_we;
    logic            gate_ready;
    logic            feat_ready;
    logic            done;
    logic [W-1:0]    gate_clamped;

    logic            adv;
    logic            s1_valid;
    logic            out_valid;

    // Gates are sigmoid outputs, so anything outside [0, 1.0] is clipped on entry.
    always_comb begin
        gate_clamped = bus.gate_in;
        if (bus.gate_in[W-1]) begin
            gate_clamped = '0;
        end else if ($signed(bus.gate_in) > Q_ONE) begin
            gate_clamped = Q_ONE;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= LOAD;
            chan_cnt_q <= '0;
            pix_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            chan_cnt_q <= chan_cnt_d;
            pix_cnt_q  <= pix_cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        chan_cnt_d = chan_cnt_q;
        pix_cnt_d  = pix_cnt_q;
        gate_ready = 1'b0;
        feat_ready = 1'b0;
        gate_we    = 1'b0;
        done       = 1'b0;
        case (state_q)
            LOAD: begin
                gate_ready = 1'b1;
                if (bus.gate_valid) begin
                    gate_we = 1'b1;
                    if (chan_cnt_q == CHAN_LAST) begin
                        chan_cnt_d = '0;
                        state_d    = SCALE;
                    end else begin
                        chan_cnt_d = chan_cnt_q + 1'b1;
                    end
                end
            end
            SCALE: begin
                feat_ready = adv;
                if (bus.feat_valid && adv) begin
                    if (chan_cnt_q == CHAN_LAST) begin
                        chan_cnt_d = '0;
                        if (pix_cnt_q == PIX_LAST) begin
                            pix_cnt_d = '0;
                            state_d   = DRAIN;
                        end else begin
                            pix_cnt_d = pix_cnt_q + 1'b1;
                        end
                    end else begin
                        chan_cnt_d = chan_cnt_q + 1'b1;
                    end
                end
            end
            DRAIN: begin
                // No new beats enter here, so with stage 1 empty the beat leaving
                // stage 2 is the last one of the map.
                if (!s1_valid && out_valid && bus.out_ready) begin
                    done    = 1'b1;
                    state_d = LOAD;
                end
            end
            default: begin
                state_d = LOAD;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < pCHANNELS; i++) begin
                gate_q[i] <= '0;
            end
        end else if (gate_we) begin
            gate_q[chan_cnt_q] <= gate_clamped;
        end
    end

    fxp_mul_round_sat #(
        .pDATA_WIDTH (pDATA_WIDTH),
        .pFRAC_NUM   (pFRAC_NUM)
    ) u_mul (
        .clk         (clk),
        .rst_n       (rst),
        .in_valid_i  (bus.feat_valid && feat_ready),
        .a_i         (bus.feat_in),
        .b_i         (gate_q[chan_cnt_q]),
        .out_ready_i (bus.out_ready),
        .adv_o       (adv),
        .s1_valid_o  (s1_valid),
        .out_valid_o (out_valid),
        .out_data_o  (bus.out_data)
    );

    assign bus.gate_ready = gate_ready;
    assign bus.feat_ready = feat_ready;
    assign bus.out_valid  = out_valid;
    assign bus.done       = done;
    assign bus.busy       = (state_q != LOAD) || s1_valid || out_valid;

endmodule

// File: tb/tb_se_channel_scale.sv
// tb/tb_se_channel_scale.sv - self-checking bench for se_channel_scale
module tb_se_channel_scale;
    localparam int W = 32;
    localparam int F = 16;
    localparam int C = 4;
    localparam int P = 3;
    localparam int N = C * P;
    localparam longint HI = 64'sd2147483647;
    localparam longint LO = -64'sd2147483648;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    se_channel_scale_if #(.pDATA_WIDTH(W)) bus ();

    se_channel_scale #(
        .pDATA_WIDTH (W),
        .pFRAC_NUM   (F),
        .pCHANNELS   (C),
        .pPIXELS     (P)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    logic [W-1:0] exp_q [$];
    logic [W-1:0] gates_a [C];
    logic [W-1:0] feats_a [N];
    logic [W-1:0] dir_exp [N];
    logic [W-1:0] exp_v;
    int  beat_idx = 0;
    bit  scaling  = 1'b0;
    bit  map_done = 1'b0;
    bit  bp_en    = 1'b0;
    logic [15:0] lfsr = 16'hACE1;

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: clamp gate to [0,1.0], exact product, round half-up, floor shift, saturate.
    function automatic logic [W-1:0] model(input logic [W-1:0] f, input logic [W-1:0] g);
        longint gs, fs, p;
        gs = longint'($signed(g));
        if (gs < 0) gs = 0;
        if (gs > 65536) gs = 65536;
        fs = longint'($signed(f));
        p = (fs * gs + 64'sd32768) >>> 16;
        if (p > HI) p = HI;
        if (p < LO) p = LO;
        return p[W-1:0];
    endfunction

    always @(posedge clk) begin
        #1;
        lfsr = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
        bus.out_ready = bp_en ? lfsr[0] : 1'b1;
    end

    always @(negedge clk) begin
        if (!rst) begin
            beat_idx = 0;
        end else begin
            if (bus.out_valid && !bus.out_ready)
                chk("feat_ready_stall", {31'd0, bus.feat_ready}, 32'd0);
            if (scaling)
                chk("gate_ready_not_load", {31'd0, bus.gate_ready}, 32'd0);
            else
                chk("feat_ready_not_scale", {31'd0, bus.feat_ready}, 32'd0);
            if (bus.out_valid && bus.out_ready) begin
                chk("beat_expected", {31'd0, exp_q.size() != 0}, 32'd1);
                if (exp_q.size() != 0) begin
                    exp_v = exp_q.pop_front();
                    chk("out_data", bus.out_data, exp_v);
                end
                chk("done_last", {31'd0, bus.done}, {31'd0, beat_idx == N - 1});
                if (beat_idx == N - 1) begin
                    beat_idx = 0;
                    map_done = 1'b1;
                    scaling  = 1'b0;
                end else begin
                    beat_idx++;
                end
            end else begin
                chk("done_idle", {31'd0, bus.done}, 32'd0);
            end
        end
    end

    task automatic send_gate(input logic [W-1:0] g);
        bit got;
        repeat ($urandom_range(0, 2)) begin
            bus.gate_valid = 1'b0;
            bus.feat_valid = 1'b1;
            bus.feat_in    = $urandom;
            @(posedge clk); #1;
        end
        bus.gate_valid = 1'b1;
        bus.gate_in    = g;
        got = 1'b0;
        for (int k = 0; k < 50 && !got; k++) begin
            @(negedge clk);
            got = bus.gate_ready;
        end
        chk("gate_handshake", {31'd0, got}, 32'd1);
        @(posedge clk); #1;
        bus.gate_valid = 1'b0;
        bus.feat_valid = 1'b0;
    endtask

    task automatic send_feat(input logic [W-1:0] f, input logic [W-1:0] e);
        bit got;
        repeat ($urandom_range(0, 1)) begin
            bus.feat_valid = 1'b0;
            @(posedge clk); #1;
        end
        bus.gate_valid = 1'($urandom);
        bus.gate_in    = $urandom;
        bus.feat_valid = 1'b1;
        bus.feat_in    = f;
        got = 1'b0;
        for (int k = 0; k < 200 && !got; k++) begin
            @(negedge clk);
            got = bus.feat_ready;
        end
        chk("feat_handshake", {31'd0, got}, 32'd1);
        exp_q.push_back(e);
        @(posedge clk); #1;
        bus.feat_valid = 1'b0;
        bus.gate_valid = 1'b0;
    endtask

    task automatic run_map(input bit use_model, input int stop_after);
        for (int c = 0; c < C; c++) send_gate(gates_a[c]);
        scaling  = 1'b1;
        map_done = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (i == stop_after) return;
            send_feat(feats_a[i], use_model ? model(feats_a[i], gates_a[i % C]) : dir_exp[i]);
        end
        for (int k = 0; k < 400 && !map_done; k++) @(negedge clk);
        chk("map_done", {31'd0, map_done}, 32'd1);
        chk("beats_left", 32'(exp_q.size()), 32'd0);
        @(posedge clk); #1;
    endtask

    task automatic rand_map();
        for (int c = 0; c < C; c++) gates_a[c] = 32'($urandom_range(0, 32'h30000)) - 32'h8000;
        for (int i = 0; i < N; i++)
            feats_a[i] = ($urandom_range(0, 1) != 0) ? $urandom : 32'($urandom_range(0, 32'h80000)) - 32'h40000;
    endtask

    initial begin
        bus.gate_valid = 1'b0;
        bus.gate_in    = '0;
        bus.feat_valid = 1'b0;
        bus.feat_in    = '0;
        bus.out_ready  = 1'b1;
        rst = 1'b1;
        #2 rst = 1'b0;
        #10;
        chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("rst_out_data", bus.out_data, 32'd0);
        chk("rst_busy", {31'd0, bus.busy}, 32'd0);
        chk("rst_done", {31'd0, bus.done}, 32'd0);
        chk("rst_feat_ready", {31'd0, bus.feat_ready}, 32'd0);
        #10 rst = 1'b1;
        #1;
        chk("rst_gate_ready", {31'd0, bus.gate_ready}, 32'd1);
        @(posedge clk); #1;

        // Directed map: scaling, rounding half-up, clamp and extremes.
        gates_a = '{32'h00008000, 32'h00004000, 32'h00020000, 32'hFFFF0000};
        feats_a = '{32'h00030000, 32'hFFFE0000, 32'h7FFFFFFF, 32'h00050000,
                    32'h00000001, 32'hFFFFFFFF, 32'h80000000, 32'h7FFFFFFF,
                    32'hFFFFFFFF, 32'h00010000, 32'h12345678, 32'h80000000};
        dir_exp = '{32'h00018000, 32'hFFFF8000, 32'h7FFFFFFF, 32'h00000000,
                    32'h00000001, 32'h00000000, 32'h80000000, 32'h00000000,
                    32'h00000000, 32'h00004000, 32'h12345678, 32'h00000000};
        run_map(1'b0, N);
        chk("idle_busy", {31'd0, bus.busy}, 32'd0);

        // Same random map without and with output backpressure.
        rand_map();
        run_map(1'b1, N);
        bp_en = 1'b1;
        run_map(1'b1, N);

        // Reset in the middle of a map.
        bp_en = 1'b0;
        rand_map();
        run_map(1'b1, 5);
        rst = 1'b0;
        #1;
        chk("midrst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("midrst_busy", {31'd0, bus.busy}, 32'd0);
        chk("midrst_gate_ready", {31'd0, bus.gate_ready}, 32'd1);
        chk("midrst_feat_ready", {31'd0, bus.feat_ready}, 32'd0);
        exp_q.delete();
        scaling = 1'b0;
        repeat (2) @(posedge clk);
        #3 rst = 1'b1;
        @(posedge clk); #1;

        rand_map();
        bp_en = 1'b1;
        run_map(1'b1, N);
        rand_map();
        run_map(1'b1, N);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
